// File: rtl/gcd_unit.sv
// Iterative GCD engine (repeated subtraction) with serial operand load and FSM control.
// Optional iteration counter output enabled by defining GCD_ITER_COUNT_EN.
module gcd_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] gcd_out,
`ifdef GCD_ITER_COUNT_EN
  output logic [WIDTH-1:0] iter_count,
`endif
  output logic             done,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CALC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             calc_end;

  // Terminal condition of CALC: a zero operand or equal operands.
  assign calc_end = (a_q == '0) || (b_q == '0) || (a_q == b_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD_A;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_CALC;
      S_CALC:   if (calc_end) state_d = S_DONE;
      S_DONE:   if (start) state_d = S_LOAD_A;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so done/busy are decoded from the next state.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    gcd_d  = gcd_q;
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_LOAD_A) || (state_d == S_LOAD_B) || (state_d == S_CALC);
    unique case (state_q)
      S_LOAD_A: a_d = data_in;
      S_LOAD_B: b_d = data_in;
      S_CALC: begin
        if (b_q == '0) begin
          gcd_d = a_q;
        end else if (a_q == '0) begin
          gcd_d = b_q;
        end else if (a_q == b_q) begin
          gcd_d = a_q;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      gcd_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      gcd_q  <= gcd_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign gcd_out = gcd_q;
  assign done    = done_q;
  assign busy    = busy_q;

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_q, iter_d;

  always_comb begin
    iter_d = iter_q;
    if (state_q == S_LOAD_A) begin
      iter_d = '0;
    end else if (state_q == S_CALC && !calc_end && iter_q != '1) begin
      iter_d = iter_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

  assign iter_count = iter_q;
`endif

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit: directed and randomized operand pairs against an
// Euclid-based reference model; outputs checked every cycle at the falling edge.
module tb_gcd_unit;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] gcd_out;
  logic         done;
  logic         busy;
`ifdef GCD_ITER_COUNT_EN
  logic [W-1:0] iter_count;
`endif

  gcd_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .data_in(data_in),
    .gcd_out(gcd_out),
`ifdef GCD_ITER_COUNT_EN
    .iter_count(iter_count),
`endif
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  // Expected-output state, maintained by the driver from the model.
  logic         chk_en   = 1'b0;
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;
  logic         exp_gcd_chk = 1'b0;
  logic [W-1:0] exp_gcd  = '0;
  logic [W-1:0] exp_iter = '0;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, r;
    x = a;
    y = b;
    while (y != 0) begin
      r = x % y;
      x = y;
      y = r;
    end
    return x;
  endfunction

  // Subtraction-based GCD performs (sum of Euclid quotients - 1) subtractions.
  function automatic int unsigned n_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned x, y, r, n;
    if (a == 0 || b == 0) return 0;
    x = a;
    y = b;
    n = 0;
    while (y != 0) begin
      n += x / y;
      r = x % y;
      x = y;
      y = r;
    end
    return n - 1;
  endfunction

  task automatic check(input string name, input int unsigned got, input int unsigned want);
    vectors++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      if (exp_gcd_chk) check("gcd_out", gcd_out, exp_gcd);
`ifdef GCD_ITER_COUNT_EN
      if (exp_done) check("iter_count", iter_count, exp_iter);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_busy();
    exp_busy    = 1'b1;
    exp_done    = 1'b0;
    exp_gcd_chk = 1'b0;
  endtask

  // Drives start and both operands; returns with the DUT in its first CALC cycle.
  task automatic begin_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy);
    start = 1'b1;
    tick();
    expect_busy();
    start   = noisy;
    data_in = a;
    tick();
    data_in = b;
    tick();
    start   = 1'b0;
    data_in = W'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy);
    int unsigned n;
    n = n_sub(a, b);
    begin_op(a, b, noisy);
    for (int unsigned i = 0; i < n; i++) begin
      start = noisy && (i % 3 == 1);
      tick();
    end
    start = 1'b0;
    tick();
    exp_busy    = 1'b0;
    exp_done    = 1'b1;
    exp_gcd_chk = 1'b1;
    exp_gcd     = gcd_ref(a, b);
    exp_iter    = (n > 16'hffff) ? 16'hffff : W'(n);
  endtask

  task automatic idle_cycles(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) tick();
  endtask

  initial begin
    logic [W-1:0] ra, rb, g;
    int unsigned x, y;

    // Pin the reference model to hand-computed values.
    check("model gcd 52ad/1089", gcd_ref(16'h52ad, 16'h1089), 16'h1089);
    check("model nsub 52ad/1089", n_sub(16'h52ad, 16'h1089), 4);
    check("model gcd 35/64", gcd_ref(16'd35, 16'd64), 1);
    check("model nsub 35/64", n_sub(16'd35, 16'd64), 11);
    check("model gcd 0/12", gcd_ref(16'd0, 16'd12), 12);
    check("model gcd 0/0", gcd_ref(16'd0, 16'd0), 0);
    check("model nsub ffff/ffff", n_sub(16'hffff, 16'hffff), 0);
    check("model gcd 18/24", gcd_ref(16'd18, 16'd24), 6);

    rst = 1'b1;
    tick();
    tick();
    exp_busy    = 1'b0;
    exp_done    = 1'b0;
    exp_gcd_chk = 1'b1;
    exp_gcd     = '0;
    chk_en      = 1'b1;
    rst         = 1'b0;
    idle_cycles(2);

    run_op(16'h52ad, 16'h1089, 1'b0);
    idle_cycles(3);
    run_op(16'd35, 16'd64, 1'b0);
    idle_cycles(2);
    run_op(16'd0, 16'd12, 1'b0);
    run_op(16'd12, 16'd0, 1'b0);
    run_op(16'd0, 16'd0, 1'b0);
    run_op(16'hffff, 16'hffff, 1'b0);

    // Abort in the middle of a long computation.
    begin_op(16'd1000, 16'd3, 1'b0);
    idle_cycles(5);
    rst = 1'b1;
    tick();
    exp_busy    = 1'b0;
    exp_done    = 1'b0;
    exp_gcd_chk = 1'b1;
    exp_gcd     = '0;
    exp_iter    = '0;
    rst = 1'b0;
    idle_cycles(2);
    run_op(16'd18, 16'd24, 1'b0);

    // start held/pulsed while busy must be ignored; start in DONE restarts immediately.
    run_op(16'd100, 16'd7, 1'b1);
    run_op(16'd48, 16'd180, 1'b1);

    for (int unsigned t = 0; t < 40; t++) begin
      if (t % 2 == 0) begin
        ra = W'($urandom_range(0, 255));
        rb = W'($urandom_range(0, 255));
      end else begin
        x  = $urandom_range(1, 40);
        y  = $urandom_range(1, 40);
        g  = W'($urandom_range(1, 65535 / 40));
        ra = W'(x * g);
        rb = W'(y * g);
      end
      run_op(ra, rb, $urandom_range(0, 3) == 0);
      idle_cycles($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
